// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer
//   Sweeps an inclusive address range through a block-RAM read port that has a
//   one-cycle registered read latency, and emits the words in ascending address
//   order on a valid/ready stream with a running checksum of accepted words.
//   A 2-entry output FIFO absorbs the read latency. A "pending" flag marks that
//   the RAM data bus carries a word requested last cycle, because the RAM has
//   no read enable and its data bus is otherwise meaningless.

module mem_readback_streamer #(
   parameter int WID_MEM   = 8,
   parameter int DEPTH_MEM = 2048,
   parameter int CSUM_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [31:0]        first_addr,
   input  logic [31:0]        last_addr,
   output logic [31:0]        raddr,
   input  logic [WID_MEM-1:0] mem_dout,
   output logic [WID_MEM-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CSUM_W-1:0]  checksum
);

   localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_MEM);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // A range is rejected when it is reversed or reaches past the end of the RAM.
   function automatic logic range_illegal(input logic [31:0] lo, input logic [31:0] hi);
      range_illegal = (lo > hi) || (hi >= DEPTH_LIM);
   endfunction

   state_t               state_r;
   logic [31:0]          raddr_r;
   logic [31:0]          last_r;
   logic                 pend_r;
   logic                 pend_last_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 err_r;
   logic [CSUM_W-1:0]    csum_r;

   // Output FIFO: slot 0 is the head and drives the stream directly.
   logic                 v0_r;
   logic                 v1_r;
   logic [WID_MEM-1:0]   d0_r;
   logic [WID_MEM-1:0]   d1_r;
   logic                 l0_r;
   logic                 l1_r;

   logic                 pop_s;
   logic                 issue_s;
   logic                 last_issue_s;
   logic [2:0]           occ_s;
   logic [2:0]           lim_s;
   logic                 v0_nx_s;
   logic                 v1_nx_s;
   logic [WID_MEM-1:0]   d0_nx_s;
   logic [WID_MEM-1:0]   d1_nx_s;
   logic                 l0_nx_s;
   logic                 l1_nx_s;

   assign raddr     = raddr_r;
   assign out_data  = d0_r;
   assign out_valid = v0_r;
   assign out_last  = l0_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign checksum  = csum_r;

   // Read-issue decision: keep FIFO occupancy plus in-flight read below two
   // after this cycle's pop, which sustains one word per cycle.
   always_comb begin
      pop_s        = v0_r && out_ready;
      occ_s        = {2'b00, v0_r} + {2'b00, v1_r} + {2'b00, pend_r};
      lim_s        = 3'd2 + {2'b00, pop_s};
      issue_s      = 1'b0;
      last_issue_s = 1'b0;
      if (state_r == ST_RUN) begin
         issue_s      = (occ_s < lim_s);
         last_issue_s = (occ_s < lim_s) && (raddr_r == last_r);
      end else begin
         issue_s      = 1'b0;
         last_issue_s = 1'b0;
      end
   end

   // Next FIFO contents: apply the pop first, then push the captured RAM word
   // into the first free slot.
   always_comb begin
      v0_nx_s = v0_r;
      v1_nx_s = v1_r;
      d0_nx_s = d0_r;
      d1_nx_s = d1_r;
      l0_nx_s = l0_r;
      l1_nx_s = l1_r;
      if (pop_s) begin
         v0_nx_s = v1_r;
         v1_nx_s = 1'b0;
         d0_nx_s = d1_r;
         l0_nx_s = l1_r;
      end else begin
         v0_nx_s = v0_r;
         v1_nx_s = v1_r;
      end
      if (pend_r) begin
         if (!v0_nx_s) begin
            v0_nx_s = 1'b1;
            d0_nx_s = mem_dout;
            l0_nx_s = pend_last_r;
         end else begin
            v1_nx_s = 1'b1;
            d1_nx_s = mem_dout;
            l1_nx_s = pend_last_r;
         end
      end else begin
         v1_nx_s = v1_nx_s;
      end
   end

   // Sweep controller: state, read address, FIFO, checksum and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         raddr_r     <= 32'd0;
         last_r      <= 32'd0;
         pend_r      <= 1'b0;
         pend_last_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         csum_r      <= '0;
         v0_r        <= 1'b0;
         v1_r        <= 1'b0;
         d0_r        <= '0;
         d1_r        <= '0;
         l0_r        <= 1'b0;
         l1_r        <= 1'b0;
      end else if (abort) begin
         // Abort flushes everything in flight; the address and checksum hold.
         state_r     <= ST_IDLE;
         pend_r      <= 1'b0;
         pend_last_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         v0_r        <= 1'b0;
         v1_r        <= 1'b0;
         l0_r        <= 1'b0;
         l1_r        <= 1'b0;
      end else begin
         v0_r        <= v0_nx_s;
         v1_r        <= v1_nx_s;
         d0_r        <= d0_nx_s;
         d1_r        <= d1_nx_s;
         l0_r        <= l0_nx_s;
         l1_r        <= l1_nx_s;
         pend_r      <= issue_s;
         pend_last_r <= last_issue_s;

         if (issue_s) begin
            raddr_r <= raddr_r + 32'd1;
         end else begin
            raddr_r <= raddr_r;
         end

         if (pop_s) begin
            csum_r <= csum_r + CSUM_W'(d0_r);
         end else begin
            csum_r <= csum_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  last_r <= last_addr;
                  csum_r <= '0;
                  if (range_illegal(first_addr, last_addr)) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     err_r   <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     raddr_r <= first_addr;
                     busy_r  <= 1'b1;
                     done_r  <= 1'b0;
                     err_r   <= 1'b0;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (last_issue_s) begin
                  state_r <= ST_DRAIN;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (pop_s && l0_r) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  err_r   <= 1'b0;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               err_r   <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               err_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Self-checking bench for mem_readback_streamer: a behavioural RAM with one
// cycle read latency feeds the DUT; expected word sequences, checksums and
// timing come from the address range and RAM contents.

module tb_mem_readback_streamer;

   localparam int WID_MEM   = 8;
   localparam int DEPTH_MEM = 2048;
   localparam int CSUM_W    = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                abort;
   logic [31:0]         first_addr;
   logic [31:0]         last_addr;
   logic [31:0]         raddr;
   logic [WID_MEM-1:0]  mem_dout = 8'h00;
   logic [WID_MEM-1:0]  out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;
   logic                busy;
   logic                done;
   logic                err;
   logic [CSUM_W-1:0]   checksum;

   logic [7:0]          ram [0:DEPTH_MEM-1];
   int                  n_checks = 0;
   int                  n_fail   = 0;

   always #5 clk = ~clk;

   mem_readback_streamer #(
      .WID_MEM   (WID_MEM),
      .DEPTH_MEM (DEPTH_MEM),
      .CSUM_W    (CSUM_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .raddr      (raddr),
      .mem_dout   (mem_dout),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum)
   );

   // Block RAM with registered read and no read enable.
   always @(posedge clk) begin
      mem_dout <= (raddr < 32'(DEPTH_MEM)) ? ram[raddr[10:0]] : 8'h00;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick_ready(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      else if (mode == 1) return (cyc % 2) == 1;
      else return $urandom_range(0, 3) != 0;
   endfunction

   // Runs one sweep from start to the idle cycle after done, checking the stream.
   task automatic do_sweep(input logic [31:0] f, input logic [31:0] l, input int mode);
      logic [7:0]  exp_q[$];
      logic [15:0] exp_sum;
      logic [31:0] raddr0;
      logic [7:0]  held_d;
      logic        held_l;
      logic        stalled;
      bit          bad;
      int          n, idx, cyc, done_cyc, last_hs, limit;

      exp_sum = 16'h0000;
      bad = (f > l) || (l >= 32'(DEPTH_MEM));
      if (!bad) begin
         for (logic [31:0] a = f; a <= l; a++) begin
            exp_q.push_back(ram[a[10:0]]);
            exp_sum += 16'(ram[a[10:0]]);
         end
      end
      n = exp_q.size();
      idx = 0; done_cyc = -1; last_hs = -1; stalled = 1'b0;
      held_d = 8'h00; held_l = 1'b0;
      limit = 8 * n + 40;

      @(posedge clk); #1;
      start = 1'b1; first_addr = f; last_addr = l;
      out_ready = pick_ready(mode, 0);
      @(negedge clk);
      raddr0 = raddr;
      check_eq("busy_c0", 32'(busy), 32'd0);
      cyc = 0;
      while (done_cyc < 0 && cyc < limit) begin
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         out_ready = pick_ready(mode, cyc);
         @(negedge clk);
         if (cyc == 1) begin
            check_eq("busy_c1", 32'(busy), 32'(!bad));
            if (bad) check_eq("raddr_noissue", raddr, raddr0);
            else     check_eq("raddr_c1", raddr, f);
         end
         if (mode == 0 && !bad) begin
            check_eq("valid_timing", 32'(out_valid), 32'(cyc >= 3 && cyc <= n + 2));
            if (cyc <= n) check_eq("raddr_seq", raddr, f + 32'(cyc - 1));
         end
         if (out_valid) begin
            if (idx >= n) begin
               check_eq("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
               if (stalled) begin
                  check_eq("stall_data", 32'(out_data), 32'(held_d));
                  check_eq("stall_last", 32'(out_last), 32'(held_l));
               end
               check_eq("data", 32'(out_data), 32'(exp_q[idx]));
               check_eq("last", 32'(out_last), 32'(idx == n - 1));
               if (out_ready) begin
                  idx++;
                  last_hs = cyc;
                  stalled = 1'b0;
               end else begin
                  stalled = 1'b1;
                  held_d  = out_data;
                  held_l  = out_last;
               end
            end
         end
         if (done) done_cyc = cyc;
      end

      check_eq("done_seen", 32'(done_cyc >= 0), 32'd1);
      if (done_cyc >= 0) begin
         check_eq("err", 32'(err), 32'(bad));
         check_eq("word_count", 32'(idx), 32'(n));
         if (bad)            check_eq("done_cyc", 32'(done_cyc), 32'd1);
         else if (mode == 0) check_eq("done_cyc", 32'(done_cyc), 32'(n + 3));
         else                check_eq("done_cyc", 32'(done_cyc), 32'(last_hs + 1));
         check_eq("checksum", 32'(checksum), bad ? 32'd0 : 32'(exp_sum));
      end
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("after_done", 32'(done), 32'd0);
      check_eq("after_busy", 32'(busy), 32'd0);
      check_eq("after_err",  32'(err),  32'd0);
   endtask

   // Reset in cycle 100 of a full sweep, then a short restart.
   task automatic reset_mid_sweep();
      @(posedge clk); #1;
      start = 1'b1; first_addr = 32'd0; last_addr = 32'd2047; out_ready = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
      check_eq("pre_rst_busy",  32'(busy),      32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_valid",    32'(out_valid), 32'd0);
      check_eq("arst_busy",     32'(busy),      32'd0);
      check_eq("arst_raddr",    raddr,          32'd0);
      check_eq("arst_checksum", 32'(checksum),  32'd0);
      check_eq("arst_last",     32'(out_last),  32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      do_sweep(32'd0, 32'd3, 0);
   endtask

   // Abort in cycle 50 while start is held high through the sweep.
   task automatic abort_mid_sweep();
      logic [15:0] exp_sum;
      exp_sum = 16'h0000;
      @(posedge clk); #1;
      start = 1'b1; first_addr = 32'd0; last_addr = 32'd2047; out_ready = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk); #1;
         if (c == 50) abort = 1'b1;
         @(negedge clk);
         check_eq("ab_busy", 32'(busy), 32'd1);
         check_eq("ab_done", 32'(done), 32'd0);
         if (c >= 3) begin
            check_eq("ab_valid", 32'(out_valid), 32'd1);
            check_eq("ab_data",  32'(out_data),  32'((c - 3) % 256));
            if (c < 50) exp_sum += 16'((c - 3) % 256);
         end
      end
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_eq("post_ab_busy",  32'(busy),      32'd0);
         check_eq("post_ab_valid", 32'(out_valid), 32'd0);
         check_eq("post_ab_done",  32'(done),      32'd0);
         check_eq("post_ab_csum",  32'(checksum),  32'(exp_sum));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] f, l, t;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      first_addr = 32'd0; last_addr = 32'd0; out_ready = 1'b0;
      for (int i = 0; i < DEPTH_MEM; i++) ram[i] = 8'(i);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_raddr",    raddr,          32'd0);
      check_eq("rst_valid",    32'(out_valid), 32'd0);
      check_eq("rst_last",     32'(out_last),  32'd0);
      check_eq("rst_busy",     32'(busy),      32'd0);
      check_eq("rst_done",     32'(done),      32'd0);
      check_eq("rst_err",      32'(err),       32'd0);
      check_eq("rst_checksum", 32'(checksum),  32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      do_sweep(32'd0, 32'd2047, 0);     // full RAM, checksum FC00
      do_sweep(32'd10, 32'd13, 1);      // alternating ready
      do_sweep(32'd5, 32'd5, 0);        // single word
      do_sweep(32'd7, 32'd3, 0);        // reversed range
      do_sweep(32'd0, 32'd2048, 0);     // past end of RAM
      reset_mid_sweep();
      abort_mid_sweep();
      do_sweep(32'd2040, 32'd2047, 2);  // top of RAM, random ready

      for (int i = 0; i < DEPTH_MEM; i++) ram[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 12; k++) begin
         f = 32'($urandom_range(0, DEPTH_MEM - 1));
         l = f + 32'($urandom_range(0, 39));
         if (k % 5 == 4) begin
            t = f; f = l + 32'd1; l = t;
         end
         do_sweep(f, l, (k % 3 == 0) ? 0 : 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
